seven_seg_scanner: RTL and testbench

- Downstream consumer of the 2-bit display refresh counter: turns the counter's digit select into multiplexed anode and segment drive for the calculator's 4-digit seven-segment display.
- Holds a double-buffered display value accepted over a valid/ready handshake. A new value only reaches the display at a frame boundary, so a frame never mixes old and new digits.
- Also provides leading-zero blanking, a minus sign, and blinking.

---
 rtl/seven_seg_scanner.sv | 164 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// seven_seg_scanner: multiplexed drive for a DIGITS-wide seven-segment display.
//   The upstream refresh counter selects the digit. Display values arrive over a
//   valid/ready handshake into a pending buffer. The pending buffer is copied to the
//   active buffer only at a frame wrap, so a frame never mixes old and new digits.
//   The block also does leading-zero blanking, a minus sign and whole-display blink.
// Ports:
//   refresh_clock, reset   : clock and async active-high reset
//   refresh_counter        : digit select, 0 = rightmost digit
//   load_valid/load_ready  : handshake for {load_value, load_neg, load_lzb}
//   blink_en               : blink the whole display every BLINK_FRAMES/2 frames
//   anode, seg             : active-low digit enables and segments {g,f,e,d,c,b,a}
//   frame_tick             : one-cycle pulse after each frame wrap
module seven_seg_scanner #(
  parameter int SEL_W        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    refresh_clock,
  input  logic                    reset,
  input  logic [SEL_W-1:0]        refresh_counter,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*(2**SEL_W)-1:0] load_value,
  input  logic                    load_neg,
  input  logic                    load_lzb,
  input  logic                    blink_en,
  output logic [(2**SEL_W)-1:0]   anode,
  output logic [6:0]              seg,
  output logic                    frame_tick
);

  localparam int DIGITS = 2**SEL_W;
  localparam int VAL_W  = 4*DIGITS;
  localparam int BC_W   = $clog2(BLINK_FRAMES);

  logic             pend_full_q, pend_full_d;
  logic [VAL_W-1:0] pend_value_q, pend_value_d;
  logic             pend_neg_q, pend_neg_d;
  logic             pend_lzb_q, pend_lzb_d;
  logic [VAL_W-1:0] act_value_q, act_value_d;
  logic             act_neg_q, act_neg_d;
  logic             act_lzb_q, act_lzb_d;
  logic [SEL_W-1:0] prev_sel_q;
  logic [BC_W-1:0]  blink_cnt_q, blink_cnt_d;
  logic             frame_tick_q;
  logic [DIGITS-1:0] anode_q, anode_d;
  logic [6:0]       seg_q, seg_d;

  logic wrap, xfer, commit;

  function automatic logic [6:0] hex_glyph(input logic [3:0] h);
    case (h)
      4'h0: hex_glyph = 7'b1000000;
      4'h1: hex_glyph = 7'b1111001;
      4'h2: hex_glyph = 7'b0100100;
      4'h3: hex_glyph = 7'b0110000;
      4'h4: hex_glyph = 7'b0011001;
      4'h5: hex_glyph = 7'b0010010;
      4'h6: hex_glyph = 7'b0000010;
      4'h7: hex_glyph = 7'b1111000;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0010000;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b0000011;
      4'hC: hex_glyph = 7'b1000110;
      4'hD: hex_glyph = 7'b0100001;
      4'hE: hex_glyph = 7'b0000110;
      default: hex_glyph = 7'b0001110;
    endcase
  endfunction

  assign load_ready = !pend_full_q;
  assign wrap   = (prev_sel_q == SEL_W'(DIGITS-1)) && (refresh_counter == '0);
  assign xfer   = load_valid && !pend_full_q;
  // xfer needs an empty pending buffer and commit needs a full one, so they never coincide.
  assign commit = wrap && pend_full_q;

  always_comb begin
    pend_full_d  = pend_full_q;
    pend_value_d = pend_value_q;
    pend_neg_d   = pend_neg_q;
    pend_lzb_d   = pend_lzb_q;
    act_value_d  = act_value_q;
    act_neg_d    = act_neg_q;
    act_lzb_d    = act_lzb_q;
    if (commit) begin
      act_value_d = pend_value_q;
      act_neg_d   = pend_neg_q;
      act_lzb_d   = pend_lzb_q;
      pend_full_d = 1'b0;
    end
    if (xfer) begin
      pend_value_d = load_value;
      pend_neg_d   = load_neg;
      pend_lzb_d   = load_lzb;
      pend_full_d  = 1'b1;
    end
  end

  assign blink_cnt_d = wrap ? blink_cnt_q + 1'b1 : blink_cnt_q;

  // Decode from the next-state active buffer and blink count. The digit-0 slot of
  // a new frame is decoded in the wrap cycle itself, so it shows the committed value.
  always_comb begin
    int  d_idx;
    int  top;
    logic blank;
    d_idx = int'(refresh_counter);
    top   = act_neg_d ? DIGITS-1 : DIGITS;
    blank = act_lzb_d && (d_idx != 0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= d_idx && j < top && act_value_d[4*j +: 4] != 4'h0) begin
        blank = 1'b0;
      end
    end
    anode_d = ~(DIGITS'(1) << refresh_counter);
    if (act_neg_d && d_idx == DIGITS-1) begin
      seg_d = 7'b0111111;
    end else if (blank) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = hex_glyph(act_value_d[4*d_idx +: 4]);
    end
    // The upper half of the blink period is the dark half.
    if (blink_en && blink_cnt_d[BC_W-1]) begin
      anode_d = '1;
      seg_d   = 7'h7F;
    end
  end

  always_ff @(posedge refresh_clock or posedge reset) begin
    if (reset) begin
      pend_full_q  <= 1'b0;
      pend_value_q <= '0;
      pend_neg_q   <= 1'b0;
      pend_lzb_q   <= 1'b0;
      act_value_q  <= '0;
      act_neg_q    <= 1'b0;
      act_lzb_q    <= 1'b0;
      prev_sel_q   <= '0;
      blink_cnt_q  <= '0;
      frame_tick_q <= 1'b0;
      anode_q      <= '1;
      seg_q        <= 7'h7F;
    end else begin
      pend_full_q  <= pend_full_d;
      pend_value_q <= pend_value_d;
      pend_neg_q   <= pend_neg_d;
      pend_lzb_q   <= pend_lzb_d;
      act_value_q  <= act_value_d;
      act_neg_q    <= act_neg_d;
      act_lzb_q    <= act_lzb_d;
      prev_sel_q   <= refresh_counter;
      blink_cnt_q  <= blink_cnt_d;
      frame_tick_q <= wrap;
      anode_q      <= anode_d;
      seg_q        <= seg_d;
    end
  end

  assign anode      = anode_q;
  assign seg        = seg_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb_seven_seg_scanner: directed bench for seven_seg_scanner (4 digits, 4-frame blink).
//   Steps the refresh counter by hand, offers loads at chosen slots and compares
//   anode/seg/frame_tick/load_ready against hand-computed glyph vectors.
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  refresh_counter;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_value;
  logic        load_neg;
  logic        load_lzb;
  logic        blink_en;
  logic [3:0]  anode;
  logic [6:0]  seg;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] G0 = 7'b1000000, G1 = 7'b1111001, G2 = 7'b0100100,
                         G3 = 7'b0110000, G5 = 7'b0010010, G7 = 7'b1111000,
                         GA = 7'b0001000, GC = 7'b1000110, GD = 7'b0100001,
                         GE = 7'b0000110, GF = 7'b0001110, GM = 7'b0111111,
                         GB = 7'h7F;
  localparam logic [27:0] ZEROS = {G0, G0, G0, G0};

  seven_seg_scanner #(.SEL_W(2), .BLINK_FRAMES(4)) dut (
    .refresh_clock   (clk),
    .reset           (reset),
    .refresh_counter (refresh_counter),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_value      (load_value),
    .load_neg        (load_neg),
    .load_lzb        (load_lzb),
    .blink_en        (blink_en),
    .anode           (anode),
    .seg             (seg),
    .frame_tick      (frame_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present select s, clock once, then check the registered digit output.
  task automatic step(input int s, input logic [6:0] eseg, input logic lit);
    logic [3:0] ea;
    refresh_counter = 2'(s);
    @(posedge clk);
    #1;
    ea = lit ? 4'(~(4'b0001 << s)) : 4'hF;
    chk("anode", {28'd0, anode}, {28'd0, ea});
    chk("seg", {25'd0, seg}, {25'd0, (lit ? eseg : GB)});
  endtask

  // One full frame of glyphs g = {d3,d2,d1,d0}; optionally offers a load at slot 1.
  task automatic frame(input logic [27:0] g, input logic lit, input logic tk,
                       input logic ld, input logic [15:0] v, input logic n, input logic z);
    for (int s = 0; s < 4; s++) begin
      if (ld && s == 1) begin
        chk("ready_pre", {31'd0, load_ready}, 32'd1);
        load_valid = 1'b1;
        load_value = v;
        load_neg   = n;
        load_lzb   = z;
      end
      step(s, g[7*s +: 7], lit);
      if (s == 0) begin
        chk("ftick", {31'd0, frame_tick}, {31'd0, tk});
        chk("ready_after_wrap", {31'd0, load_ready}, 32'd1);
      end
      if (s == 1) chk("ftick_low", {31'd0, frame_tick}, 32'd0);
      if (ld && s == 1) begin
        chk("ready_drop", {31'd0, load_ready}, 32'd0);
        load_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    refresh_counter = 2'd0;
    load_valid = 1'b0;
    load_value = 16'h0;
    load_neg = 1'b0;
    load_lzb = 1'b0;
    blink_en = 1'b0;
    #3;
    chk("rst_anode", {28'd0, anode}, 32'hF);
    chk("rst_seg", {25'd0, seg}, 32'h7F);
    chk("rst_ftick", {31'd0, frame_tick}, 32'd0);
    chk("rst_ready", {31'd0, load_ready}, 32'd1);
    #9 reset = 1'b0;

    // Idle after reset shows "0000"; second frame takes 12AF at slot 1.
    frame(ZEROS, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    frame(ZEROS, 1'b1, 1'b1, 1'b1, 16'h12AF, 1'b0, 1'b0);
    // 12AF visible; load 0005 with blanking.
    frame({G1, G2, GA, GF}, 1'b1, 1'b1, 1'b1, 16'h0005, 1'b0, 1'b1);
    // 0005 blanked to "   5"; load 0007 negative with blanking.
    frame({GB, GB, GB, G5}, 1'b1, 1'b1, 1'b1, 16'h0007, 1'b1, 1'b1);

    // "-  7" frame with two back-to-back offers: 3210 then C0DE.
    step(0, G7, 1'b1);
    load_valid = 1'b1; load_value = 16'h3210; load_neg = 1'b0; load_lzb = 1'b0;
    step(1, GB, 1'b1);
    chk("b2b_first_taken", {31'd0, load_ready}, 32'd0);
    load_value = 16'hC0DE;
    step(2, GB, 1'b1);
    chk("b2b_second_held", {31'd0, load_ready}, 32'd0);
    step(3, GM, 1'b1);
    chk("b2b_held_pre_wrap", {31'd0, load_ready}, 32'd0);
    step(0, G0, 1'b1);
    chk("b2b_ready_after_wrap", {31'd0, load_ready}, 32'd1);
    step(1, G1, 1'b1);
    chk("b2b_second_taken", {31'd0, load_ready}, 32'd0);
    load_valid = 1'b0;
    step(2, G2, 1'b1);
    step(3, G3, 1'b1);
    frame({GC, G0, GD, GE}, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    // Blink: reset to a known frame count; counter runs while blink_en is low.
    @(negedge clk);
    reset = 1'b1;
    #2 reset = 1'b0;
    frame(ZEROS, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);  // count 0
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 1
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 2, blink off
    blink_en = 1'b1;
    frame(ZEROS, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 3
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 0
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 1
    frame(ZEROS, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 2
    frame(ZEROS, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 3
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);  // count 0
    blink_en = 1'b0;

    // Reset mid-frame with a value pending: it must be discarded.
    step(0, G0, 1'b1);
    load_valid = 1'b1; load_value = 16'h8888; load_neg = 1'b0; load_lzb = 1'b0;
    step(1, G0, 1'b1);
    load_valid = 1'b0;
    chk("mid_pending", {31'd0, load_ready}, 32'd0);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_anode", {28'd0, anode}, 32'hF);
    chk("mid_rst_seg", {25'd0, seg}, 32'h7F);
    chk("mid_rst_ready", {31'd0, load_ready}, 32'd1);
    chk("mid_rst_ftick", {31'd0, frame_tick}, 32'd0);
    #3 reset = 1'b0;
    frame(ZEROS, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    frame(ZEROS, 1'b1, 1'b1, 1'b0, 16'h0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
